// File: rtl/mr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : mr_wb_arb
// Description : Two-source writeback arbiter for the decode-stage register
//               file write port. src0 (ALU) has fixed priority, src1 (load)
//               gets forced priority after STARVE_LIMIT denied cycles and
//               also wins same-register collisions. Writes to x0 are sunk
//               without occupying the port. Output is a registered pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mr_wb_arb #(
    parameter int XLEN         = 32,
    parameter int REGSEL_BITS  = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src0_valid,
    output logic                   src0_ready,
    input  logic [REGSEL_BITS-1:0] src0_reg,
    input  logic [XLEN-1:0]        src0_val,
    input  logic                   src1_valid,
    output logic                   src1_ready,
    input  logic [REGSEL_BITS-1:0] src1_reg,
    input  logic [XLEN-1:0]        src1_val,
    output logic                   wb_valid,
    output logic [REGSEL_BITS-1:0] wb_reg,
    output logic [XLEN-1:0]        wb_val,
    output logic [15:0]            collide_cnt
);

    localparam logic [3:0]  c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0]  c_STARVE_MAX   = 4'hF;
    localparam logic [15:0] c_COLLIDE_MAX  = 16'hFFFF;

    logic                   r_wb_valid;
    logic [REGSEL_BITS-1:0] r_wb_reg;
    logic [XLEN-1:0]        r_wb_val;
    logic [3:0]             r_starve_cnt;
    logic [15:0]            r_collide_cnt;

    logic w_s0_req;      // src0 wants the port (nonzero destination)
    logic w_s1_req;      // src1 wants the port (nonzero destination)
    logic w_s0_sink;     // src0 targets x0, consumed without a write
    logic w_s1_sink;     // src1 targets x0, consumed without a write
    logic w_contend;     // both sources compete for the port
    logic w_s0_win;
    logic w_s1_win;

    // Request classification and grant decision among nonzero-register requests
    always_comb begin
        w_s0_req  = src0_valid && (src0_reg != '0);
        w_s1_req  = src1_valid && (src1_reg != '0);
        w_s0_sink = src0_valid && (src0_reg == '0);
        w_s1_sink = src1_valid && (src1_reg == '0);
        w_contend = w_s0_req && w_s1_req;
        // Load wins when alone, when starved, or when both target the same
        // register so the older load result is retired before the ALU value.
        w_s1_win  = w_s1_req && (!w_s0_req
                                 || (r_starve_cnt >= c_STARVE_LIMIT)
                                 || (src0_reg == src1_reg));
        w_s0_win  = w_s0_req && !w_s1_win;
    end

    // Readies are suppressed for the whole duration of reset
    always_comb begin
        src0_ready = !rst && (w_s0_sink || w_s0_win);
        src1_ready = !rst && (w_s1_sink || w_s1_win);
    end

    // Registered one-cycle write pulse; data holds its last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_val   <= '0;
        end else if (w_s1_win) begin
            r_wb_valid <= 1'b1;
            r_wb_reg   <= src1_reg;
            r_wb_val   <= src1_val;
        end else if (w_s0_win) begin
            r_wb_valid <= 1'b1;
            r_wb_reg   <= src0_reg;
            r_wb_val   <= src0_val;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    // Track consecutive denied cycles of the load source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!src1_valid || w_s1_win || w_s1_sink) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Saturating count of contended cycles (one source is always denied)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collide_cnt <= '0;
        end else if (w_contend && (r_collide_cnt != c_COLLIDE_MAX)) begin
            r_collide_cnt <= r_collide_cnt + 16'd1;
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_reg      = r_wb_reg;
    assign wb_val      = r_wb_val;
    assign collide_cnt = r_collide_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mr_wb_arb
// Description : Directed self-checking bench for mr_wb_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mr_wb_arb;

    localparam int XLEN         = 32;
    localparam int REGSEL_BITS  = 5;
    localparam int STARVE_LIMIT = 4;

    logic                   clk;
    logic                   rst;
    logic                   src0_valid;
    logic                   src0_ready;
    logic [REGSEL_BITS-1:0] src0_reg;
    logic [XLEN-1:0]        src0_val;
    logic                   src1_valid;
    logic                   src1_ready;
    logic [REGSEL_BITS-1:0] src1_reg;
    logic [XLEN-1:0]        src1_val;
    logic                   wb_valid;
    logic [REGSEL_BITS-1:0] wb_reg;
    logic [XLEN-1:0]        wb_val;
    logic [15:0]            collide_cnt;

    int n_cmp;
    int n_err;

    mr_wb_arb #(
        .XLEN        (XLEN),
        .REGSEL_BITS (REGSEL_BITS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .src0_valid (src0_valid),
        .src0_ready (src0_ready),
        .src0_reg   (src0_reg),
        .src0_val   (src0_val),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .src1_reg   (src1_reg),
        .src1_val   (src1_val),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_val     (wb_val),
        .collide_cnt(collide_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src0_valid = 1'b1; src0_reg = 5'd5; src0_val = 32'h1234;
        src1_valid = 1'b1; src1_reg = 5'd6; src1_val = 32'h5678;
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
        n_cmp++; if (wb_reg !== 5'd0) begin n_err++; $display("FAIL rst_wb_reg: got %0d expected 0", wb_reg); end
        n_cmp++; if (wb_val !== 32'h0) begin n_err++; $display("FAIL rst_wb_val: got %h expected 0", wb_val); end
        n_cmp++; if (collide_cnt !== 16'h0) begin n_err++; $display("FAIL rst_collide: got %h expected 0", collide_cnt); end
        n_cmp++; if (src0_ready !== 1'b0) begin n_err++; $display("FAIL rst_src0_ready: got %b expected 0", src0_ready); end
        n_cmp++; if (src1_ready !== 1'b0) begin n_err++; $display("FAIL rst_src1_ready: got %b expected 0", src1_ready); end
        src0_valid = 1'b0; src1_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got %b expected 0", wb_valid); end
    endtask

    task automatic test_src0_only();
        src0_valid = 1'b1; src0_reg = 5'd5; src0_val = 32'hDEADBEEF;
        #1;
        n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL s0only_ready: got %b expected 1", src0_ready); end
        tick();
        src0_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL s0only_wb_valid: got %b expected 1", wb_valid); end
        n_cmp++; if (wb_reg !== 5'd5) begin n_err++; $display("FAIL s0only_wb_reg: got %0d expected 5", wb_reg); end
        n_cmp++; if (wb_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL s0only_wb_val: got %h expected deadbeef", wb_val); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL s0only_pulse_end: got %b expected 0", wb_valid); end
        n_cmp++; if (wb_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL s0only_val_hold: got %h expected deadbeef", wb_val); end
    endtask

    task automatic test_back_to_back();
        src0_valid = 1'b1; src0_reg = 5'd1; src0_val = 32'hA1;
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_val !== 32'hA1) begin n_err++; $display("FAIL b2b_first: got v=%b val=%h expected v=1 val=a1", wb_valid, wb_val); end
        src0_reg = 5'd2; src0_val = 32'hA2;
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg !== 5'd2 || wb_val !== 32'hA2) begin n_err++; $display("FAIL b2b_second: got v=%b reg=%0d val=%h expected v=1 reg=2 val=a2", wb_valid, wb_reg, wb_val); end
        src0_valid = 1'b0;
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b expected 0", wb_valid); end
    endtask

    // Both held valid: starve count goes 1..4 on src0 grants, src1 forced on
    // cycle 5 (count back to 0), so src1 wins on cycles 5 and 10.
    task automatic test_starve();
        logic exp_s1;
        src0_valid = 1'b1; src0_reg = 5'd3; src0_val = 32'h33;
        src1_valid = 1'b1; src1_reg = 5'd4; src1_val = 32'h44;
        for (int i = 1; i <= 10; i++) begin
            exp_s1 = (i == 5) || (i == 10);
            #1;
            n_cmp++; if (src1_ready !== exp_s1 || src0_ready !== !exp_s1) begin n_err++; $display("FAIL starve_ready_c%0d: got r0=%b r1=%b expected r0=%b r1=%b", i, src0_ready, src1_ready, !exp_s1, exp_s1); end
            if (i == 5) begin
                n_cmp++; if (collide_cnt !== 16'd4) begin n_err++; $display("FAIL starve_collide_c5: got %0d expected 4", collide_cnt); end
            end
            tick();
            n_cmp++; if (wb_valid !== 1'b1 || wb_reg !== (exp_s1 ? 5'd4 : 5'd3)) begin n_err++; $display("FAIL starve_wb_c%0d: got v=%b reg=%0d expected v=1 reg=%0d", i, wb_valid, wb_reg, exp_s1 ? 4 : 3); end
        end
        n_cmp++; if (collide_cnt !== 16'd10) begin n_err++; $display("FAIL starve_collide_end: got %0d expected 10", collide_cnt); end
        src0_valid = 1'b0; src1_valid = 1'b0;
        tick();
    endtask

    task automatic test_same_reg();
        src0_valid = 1'b1; src0_reg = 5'd7; src0_val = 32'h1;
        src1_valid = 1'b1; src1_reg = 5'd7; src1_val = 32'h2;
        #1;
        n_cmp++; if (src1_ready !== 1'b1 || src0_ready !== 1'b0) begin n_err++; $display("FAIL same_ready: got r0=%b r1=%b expected r0=0 r1=1", src0_ready, src1_ready); end
        tick();
        src1_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg !== 5'd7 || wb_val !== 32'h2) begin n_err++; $display("FAIL same_first: got v=%b reg=%0d val=%h expected v=1 reg=7 val=2", wb_valid, wb_reg, wb_val); end
        tick();
        src0_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_val !== 32'h1) begin n_err++; $display("FAIL same_second: got v=%b val=%h expected v=1 val=1", wb_valid, wb_val); end
        n_cmp++; if (collide_cnt !== 16'd11) begin n_err++; $display("FAIL same_collide: got %0d expected 11", collide_cnt); end
        tick();
    endtask

    task automatic test_sink();
        src0_valid = 1'b1; src0_reg = 5'd0; src0_val = 32'hBAD;
        src1_valid = 1'b1; src1_reg = 5'd9; src1_val = 32'h99;
        #1;
        n_cmp++; if (src0_ready !== 1'b1 || src1_ready !== 1'b1) begin n_err++; $display("FAIL sink_ready: got r0=%b r1=%b expected r0=1 r1=1", src0_ready, src1_ready); end
        tick();
        src0_valid = 1'b0; src1_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg !== 5'd9 || wb_val !== 32'h99) begin n_err++; $display("FAIL sink_wb: got v=%b reg=%0d val=%h expected v=1 reg=9 val=99", wb_valid, wb_reg, wb_val); end
        n_cmp++; if (collide_cnt !== 16'd11) begin n_err++; $display("FAIL sink_collide: got %0d expected 11", collide_cnt); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL sink_single_pulse: got %b expected 0", wb_valid); end
    endtask

    task automatic test_mid_reset();
        src0_valid = 1'b1; src0_reg = 5'd11; src0_val = 32'hB11;
        tick();
        src0_reg = 5'd12; src0_val = 32'hC12;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (wb_valid !== 1'b0 || wb_reg !== 5'd0 || wb_val !== 32'h0) begin n_err++; $display("FAIL mrst_immediate: got v=%b reg=%0d val=%h expected all 0", wb_valid, wb_reg, wb_val); end
        n_cmp++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin n_err++; $display("FAIL mrst_ready: got r0=%b r1=%b expected 0 0", src0_ready, src1_ready); end
        n_cmp++; if (collide_cnt !== 16'd0) begin n_err++; $display("FAIL mrst_collide: got %0d expected 0", collide_cnt); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL mrst_no_pulse: got %b expected 0", wb_valid); end
        src0_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        src0_valid = 1'b1; src0_reg = 5'd3; src0_val = 32'h3;
        src1_valid = 1'b1; src1_reg = 5'd4; src1_val = 32'h4;
        repeat (65534) tick();
        n_cmp++; if (collide_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_before: got %h expected fffe", collide_cnt); end
        repeat (70000 - 65534) tick();
        n_cmp++; if (collide_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h expected ffff", collide_cnt); end
        src0_valid = 1'b0; src1_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        src0_valid = 1'b0; src0_reg = '0; src0_val = '0;
        src1_valid = 1'b0; src1_reg = '0; src1_val = '0;
        test_reset();
        test_src0_only();
        test_back_to_back();
        test_starve();
        test_same_reg();
        test_sink();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mr_wb_arb.md
Name: mr_wb_arb

Overview:
- Arbitrates the single register-file write port of the decode stage (wb_valid/wb_reg/wb_val) between two writeback sources: src0 is the ALU/execute result, src1 is the memory load result.
- Sources use valid/ready handshakes; the output is a registered one-cycle write pulse.
- Fixed priority favours src0, with a starvation limit that guarantees src1 progress.
- Writes to x0 are sunk without using the port.

Parameters:
- XLEN, 32, data width.
- REGSEL_BITS, 5, register select width.
- STARVE_LIMIT, 4, consecutive cycles src1 may be denied before it gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- src0_valid  in  1  ALU writeback request
- src0_ready  out  1  src0 accepted this cycle
- src0_reg  in  REGSEL_BITS  destination register
- src0_val  in  XLEN  write data
- src1_valid  in  1  load writeback request
- src1_ready  out  1  src1 accepted this cycle
- src1_reg  in  REGSEL_BITS  destination register
- src1_val  in  XLEN  write data
- wb_valid  out  1  registered write pulse to decode
- wb_reg  out  REGSEL_BITS  registered destination
- wb_val  out  XLEN  registered data
- collide_cnt  out  16  saturating count of cycles where both sources requested a nonzero register and one was denied

Behaviour:
- Reset (async, active-high):
  - wb_valid=0, wb_reg=0, wb_val=0, starve_cnt=0, collide_cnt=0.
  - src0_ready and src1_ready are forced to 0 while rst is high.
- Handshake:
  - srcN_ready is combinational from the valids, regs and starve_cnt.
  - A transfer occurs when valid&ready.
  - Sources hold reg/val stable until accepted.
- Sink rule: a request with reg==0 is always ready (outside reset) and produces no wb_valid pulse. Such a request never blocks or counts as a competitor.
- Grant, among requests with nonzero reg:
  - Only src0 valid: src0 is granted.
  - Only src1 valid: src1 is granted.
  - Both valid:
    - src1 wins if starve_cnt >= STARVE_LIMIT.
    - src1 wins if src0_reg==src1_reg (same-register collision: the load is retired first).
    - Otherwise src0 wins.
    - The loser's ready is 0.
- Both sources are ready in the same cycle when one of them targets x0, or both do.
- Output latency:
  - A granted nonzero request appears on wb_valid/wb_reg/wb_val on the next rising edge, for exactly one cycle.
  - wb_valid=0 in cycles with no nonzero grant; wb_reg/wb_val hold their last values.
  - Back-to-back grants give continuous wb_valid=1.
- starve_cnt (4 bits):
  - Increments, saturating at 15, each cycle src1 has a nonzero request that is not granted.
  - Clears to 0 on any src1 grant, or whenever src1_valid=0.
- collide_cnt increments by 1 per denied-contention cycle and saturates at 0xFFFF.
- Reset mid-operation: any pending grant is dropped, and the output pulse scheduled for the next edge is suppressed. Sources must re-present their requests after reset.
- No internal buffering: capacity is one transfer per cycle to the port.

Test Plan:
- src0 only, reg=5, val=0xDEADBEEF, one cycle -> src0_ready=1 same cycle; next cycle wb_valid=1, wb_reg=5, wb_val=0xDEADBEEF; following cycle wb_valid=0.
- src0 and src1 both held valid continuously (regs 3 and 4), STARVE_LIMIT=4 -> src0 granted 4 cycles, src1 on the 5th, src0 again; collide_cnt=4 after cycle 5; starve_cnt back to 0.
- Same-register collision, src0_reg=src1_reg=7, vals 0x1/0x2 -> src1 granted first (wb_val=0x2), src0 the next cycle (wb_val=0x1); collide_cnt +1.
- src0_reg=0 with src1_reg=9 in the same cycle -> both ready=1; exactly one wb_valid pulse next cycle, wb_reg=9; collide_cnt unchanged.
- rst asserted asynchronously mid-cycle after a grant -> outputs zero immediately; no wb_valid pulse on the next edge; both readies are 0 during reset.
- 70000 contended cycles -> collide_cnt saturates at 0xFFFF with no wrap.
